exception_sequencer: RTL and testbench
======================================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 The block SHALL have parameter VECTOR_ADDR, default 32'h0000_FFFC, meaning the handler entry address driven on redirect.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the exception counter.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port undef_req, input, 1, meaning an undefined instruction was decoded in ID.
REQ-006 The block SHALL have port ovf_req, input, 1, meaning arithmetic overflow was raised in EX.
REQ-007 The block SHALL have port eret, input, 1, meaning a return-from-exception was decoded in ID.
REQ-008 The block SHALL have port hold, input, 1, meaning the pipeline is frozen (memory busy).
REQ-009 The block SHALL have ports id_pc and ex_pc, input, 32 each, meaning the PC of the ID-stage and EX-stage instructions.
REQ-010 The block SHALL have ports flush_if, flush_id and flush_ex, output, 1 each, meaning squash the corresponding pipeline register.
REQ-011 The block SHALL have ports pc_redirect (output, 1) and pc_target (output, 32), meaning load pc_target into PC.
REQ-012 The block SHALL have ports epc (output, 32), cause (output, 2), in_handler (output, 1), halted (output, 1) and exc_count (output, CNT_W).

Function
REQ-013 The block SHALL implement the states IDLE, FLUSH, HANDLER, RETURN and HALT.
REQ-014 In IDLE, ovf_req=1 SHALL capture epc<=ex_pc, cause<=2'b10 and go to FLUSH at the same edge.
REQ-015 In IDLE, undef_req=1 with ovf_req=0 SHALL capture epc<=id_pc, cause<=2'b01 and go to FLUSH.
REQ-016 If ovf_req and undef_req are both 1 in the same cycle, overflow SHALL win, because EX holds the older instruction.
REQ-017 In FLUSH, the outputs SHALL be: flush_if=flush_id=flush_ex=1, pc_redirect=1 and pc_target=VECTOR_ADDR.
REQ-018 From FLUSH, the block SHALL go to HANDLER at the next edge when hold=0; while hold=1 it SHALL stay in FLUSH with all outputs held.
REQ-019 In HANDLER, in_handler SHALL be 1 and all flush and redirect outputs SHALL be 0.
REQ-020 In HANDLER, eret=1 with no exception request SHALL go to RETURN.
REQ-021 In RETURN, the outputs SHALL be: pc_redirect=1, pc_target=epc, flush_if=flush_id=1 and flush_ex=0.
REQ-022 From RETURN, the block SHALL go to IDLE when hold=0; while hold=1 it SHALL stay in RETURN with outputs held.
REQ-023 In HANDLER, any ovf_req or undef_req (double fault) SHALL go to HALT with cause<=2'b11 and epc unchanged; this SHALL take priority over a simultaneous eret.
REQ-024 In HALT, halted=1, flush_if=flush_id=flush_ex=1 and pc_redirect=0; only reset SHALL exit HALT.
REQ-025 Requests arriving in FLUSH or RETURN SHALL be ignored, since the pipeline is being squashed.
REQ-026 eret in IDLE SHALL be ignored.
REQ-027 cause SHALL retain its last value after return; it SHALL be 2'b00 only from reset.
REQ-028 exc_count SHALL increment by 1 on every IDLE->FLUSH and HANDLER->HALT transition and SHALL saturate at all-ones (no wrap).
REQ-029 All outputs SHALL be decoded from state and registered values only, with no combinational path from request inputs to outputs; exception entry latency is therefore exactly 1 cycle from request to flush/redirect.

Reset
REQ-030 Assertion of reset (reset=0) SHALL asynchronously force state=IDLE, epc=0, cause=2'b00, exc_count=0 and all 1-bit outputs to 0; pc_target SHALL read 0 in IDLE.
REQ-031 Reset asserted in any state, including mid-FLUSH or HALT, SHALL abort the sequence; after deassertion the block SHALL sample requests from the first rising edge.

Structure
REQ-032 A shared package SHALL hold the state enumeration and the cause constants CAUSE_NONE=2'b00, CAUSE_UNDEF=2'b01, CAUSE_ARITH=2'b10 and CAUSE_DOUBLE=2'b11.
REQ-033 The saturating counter SHALL be the single sub-module sat_counter, with parameter width, an increment enable and the same clock and reset.

Verification
REQ-034 The bench SHALL cover: ovf_req pulse with ex_pc=32'h0000_0040 -> next cycle flush_if/id/ex=1 and pc_target=32'h0000_FFFC; then epc=32'h40, cause=2'b10, in_handler=1.
REQ-035 The bench SHALL cover: undef_req and ovf_req together with id_pc=0x44 and ex_pc=0x40 -> epc=0x40, cause=2'b10, exc_count=1.
REQ-036 The bench SHALL cover: in HANDLER, eret pulse -> one cycle of pc_redirect=1, pc_target=epc, flush_ex=0, then IDLE with cause still 2'b10.
REQ-037 The bench SHALL cover: in HANDLER, undef_req together with eret -> HALT, cause=2'b11, epc unchanged, halted=1 until reset.
REQ-038 The bench SHALL cover: hold=1 for 3 cycles during FLUSH -> outputs stable for 4 cycles total, then HANDLER.
REQ-039 The bench SHALL cover: 300 exceptions with CNT_W=8 -> exc_count=8'hFF; and reset asserted mid-FLUSH -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exception_sequencer_pkg.sv
// exception_sequencer_pkg: shared state encoding and cause codes for the exception sequencer.
package exception_sequencer_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        HANDLER,
        RETURN,
        HALT
    } state_t;
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_UNDEF  = 2'b01;
    localparam logic [1:0] CAUSE_ARITH  = 2'b10;
    localparam logic [1:0] CAUSE_DOUBLE = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on enable and sticks at all-ones.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);
    logic [width-1:0] r_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_count <= '0;
        else if (inc && r_count != '1) r_count <= r_count + 1'b1;
    end
    assign count = r_count;
endmodule

// File: rtl/exception_sequencer.sv
// exception_sequencer: pipeline exception entry/return sequencer with double-fault halt.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_FFFC,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             undef_req,
    input  logic             ovf_req,
    input  logic             eret,
    input  logic             hold,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      ex_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic             in_handler,
    output logic             halted,
    output logic [CNT_W-1:0] exc_count
);
    state_t      r_state, w_next;
    logic [31:0] r_epc;
    logic [1:0]  r_cause;
    logic        w_req, w_inc;
    assign w_req = undef_req | ovf_req;
    assign w_inc = w_req && (r_state == IDLE || r_state == HANDLER);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_epc   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_epc   <= ovf_req ? ex_pc : id_pc;
                r_cause <= ovf_req ? CAUSE_ARITH : CAUSE_UNDEF;
            end else if (r_state == HANDLER && w_req) begin
                r_cause <= CAUSE_DOUBLE;
            end
        end
    end
    // A fault inside the handler outranks eret and is terminal.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? FLUSH : IDLE;
            FLUSH:   w_next = hold ? FLUSH : HANDLER;
            HANDLER: w_next = w_req ? HALT : (eret ? RETURN : HANDLER);
            RETURN:  w_next = hold ? RETURN : IDLE;
            default: w_next = r_state;
        endcase
    end
    sat_counter #(.width(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc),
        .count (exc_count)
    );
    assign flush_if    = r_state == FLUSH || r_state == RETURN || r_state == HALT;
    assign flush_id    = flush_if;
    assign flush_ex    = r_state == FLUSH || r_state == HALT;
    assign pc_redirect = r_state == FLUSH || r_state == RETURN;
    assign pc_target   = r_state == FLUSH ? VECTOR_ADDR : (r_state == RETURN ? r_epc : 32'h0);
    assign in_handler  = r_state == HANDLER;
    assign halted      = r_state == HALT;
    assign epc         = r_epc;
    assign cause       = r_cause;
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed and randomized checks against a behavioural exception model.
module tb_exception_sequencer;
    localparam logic [31:0] VEC = 32'h0000_FFFC;
    localparam int M_IDLE = 0, M_FLUSH = 1, M_HANDLER = 2, M_RETURN = 3, M_HALT = 4;

    logic        clk = 0, reset = 0, undef_req = 0, ovf_req = 0, eret = 0, hold = 0;
    logic [31:0] id_pc = 0, ex_pc = 0;
    logic        flush_if, flush_id, flush_ex, pc_redirect, in_handler, halted;
    logic [31:0] pc_target, epc;
    logic [1:0]  cause;
    logic [7:0]  exc_count;
    int          n_checks = 0, n_fails = 0;

    int          m_mode;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          m_cnt;

    exception_sequencer #(.VECTOR_ADDR(VEC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .undef_req(undef_req), .ovf_req(ovf_req), .eret(eret),
        .hold(hold), .id_pc(id_pc), .ex_pc(ex_pc), .flush_if(flush_if), .flush_id(flush_id),
        .flush_ex(flush_ex), .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
        .cause(cause), .in_handler(in_handler), .halted(halted), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    wire [79:0] obs = {flush_if, flush_id, flush_ex, pc_redirect, pc_target, epc, cause,
                       in_handler, halted, exc_count};

    function automatic logic [79:0] exp_vec();
        logic sq  = m_mode inside {M_FLUSH, M_RETURN, M_HALT};
        logic sqx = m_mode inside {M_FLUSH, M_HALT};
        logic rd  = m_mode inside {M_FLUSH, M_RETURN};
        logic [31:0] tgt = m_mode == M_FLUSH ? VEC : (m_mode == M_RETURN ? m_epc : 32'h0);
        logic [7:0] c8 = m_cnt[7:0];
        return {sq, sq, sqx, rd, tgt, m_epc, m_cause, m_mode == M_HANDLER, m_mode == M_HALT, c8};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_epc = 0; m_cause = 2'b00; m_cnt = 0;
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE: if (ovf_req || undef_req) begin
                m_epc   = ovf_req ? ex_pc : id_pc;
                m_cause = ovf_req ? 2'b10 : 2'b01;
                m_cnt   = m_cnt < 255 ? m_cnt + 1 : 255;
                m_mode  = M_FLUSH;
            end
            M_FLUSH:  if (!hold) m_mode = M_HANDLER;
            M_HANDLER: if (ovf_req || undef_req) begin
                m_cause = 2'b11;
                m_cnt   = m_cnt < 255 ? m_cnt + 1 : 255;
                m_mode  = M_HALT;
            end else if (eret) m_mode = M_RETURN;
            M_RETURN: if (!hold) m_mode = M_IDLE;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic u, input logic o, input logic e, input logic h,
                          input logic [31:0] ipc, input logic [31:0] xpc);
        undef_req = u; ovf_req = o; eret = e; hold = h; id_pc = ipc; ex_pc = xpc;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        #2 reset = 0;
        #1 model_reset();
        #1 reset = 1;
    endtask

    task automatic test_reset();
        #1;
        model_reset();
        n_checks++;
        if (obs !== 80'h0) begin
            n_fails++; $display("FAIL reset_state got=%h want=%h", obs, 80'h0);
        end
        #3 reset = 1;
    endtask

    task automatic test_ovf();
        set_in(0, 1, 0, 0, 32'h44, 32'h40);
        tick();
        n_checks++;
        if ({flush_if, flush_id, flush_ex, pc_target} !== {3'b111, VEC}) begin
            n_fails++; $display("FAIL ovf_entry got=%b%b%b %h want=111 %h", flush_if, flush_id, flush_ex, pc_target, VEC);
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({epc, cause, in_handler} !== {32'h40, 2'b10, 1'b1}) begin
            n_fails++; $display("FAIL ovf_handler got epc=%h cause=%b ih=%b want 40 10 1", epc, cause, in_handler);
        end
    endtask

    task automatic test_both();
        do_reset();
        set_in(1, 1, 0, 0, 32'h44, 32'h40);
        tick();
        n_checks++;
        if ({epc, cause, exc_count} !== {32'h40, 2'b10, 8'd1}) begin
            n_fails++; $display("FAIL both_req got epc=%h cause=%b cnt=%0d want 40 10 1", epc, cause, exc_count);
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_eret();
        set_in(0, 0, 1, 0, 0, 0);
        tick();
        n_checks++;
        if ({pc_redirect, pc_target, flush_if, flush_id, flush_ex} !== {1'b1, 32'h40, 3'b110}) begin
            n_fails++; $display("FAIL eret_return got rd=%b tgt=%h fl=%b%b%b want 1 40 110", pc_redirect, pc_target, flush_if, flush_id, flush_ex);
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({pc_redirect, in_handler, flush_if, cause} !== {3'b000, 2'b10}) begin
            n_fails++; $display("FAIL eret_idle got rd=%b ih=%b fl=%b cause=%b want 0 0 0 10", pc_redirect, in_handler, flush_if, cause);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fails++; $display("FAIL eret_model got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_double();
        set_in(0, 1, 0, 0, 0, 32'h80);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 1, 0, 32'h84, 32'h88);
        tick();
        n_checks++;
        if ({halted, cause, epc, pc_redirect, flush_if, flush_id, flush_ex} !== {1'b1, 2'b11, 32'h80, 4'b0111}) begin
            n_fails++; $display("FAIL double_fault got h=%b cause=%b epc=%h rd=%b want 1 11 80 0", halted, cause, epc, pc_redirect);
        end
        for (int i = 0; i < 6; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            tick();
            n_checks++;
            if (halted !== 1'b1 || obs !== exp_vec()) begin
                n_fails++; $display("FAIL halt_sticky got=%h want=%h", obs, exp_vec());
            end
        end
        do_reset();
        n_checks++;
        if (obs !== 80'h0) begin
            n_fails++; $display("FAIL halt_reset got=%h want=0", obs);
        end
    endtask

    task automatic test_hold();
        set_in(0, 1, 0, 0, 0, 32'h100);
        tick();
        set_in(1, 1, 0, 1, 32'h5, 32'h6);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({flush_if, flush_id, flush_ex, pc_redirect, pc_target, epc} !== {4'b1111, VEC, 32'h100} || obs !== exp_vec()) begin
                n_fails++; $display("FAIL hold_flush cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (i < 3) tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (in_handler !== 1'b1 || flush_if !== 1'b0) begin
            n_fails++; $display("FAIL hold_release got ih=%b fl=%b want 1 0", in_handler, flush_if);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_in(0, 1, 0, 0, 0, 32'(i));
            tick();
            set_in(0, 0, 0, 0, 0, 0);
            tick();
            set_in(0, 0, 1, 0, 0, 0);
            tick();
            set_in(0, 0, 0, 0, 0, 0);
            tick();
            if (i == 254 || i == 299) begin
                n_checks++;
                if (exc_count !== 8'hFF || obs !== exp_vec()) begin
                    n_fails++; $display("FAIL saturate n=%0d got=%h want=ff", i + 1, exc_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        set_in(0, 1, 0, 1, 0, 32'h200);
        tick();
        #2 reset = 0;
        #1;
        n_checks++;
        if (obs !== 80'h0) begin
            n_fails++; $display("FAIL async_reset got=%h want=0", obs);
        end
        model_reset();
        set_in(0, 1, 0, 0, 0, 32'h300);
        #1 reset = 1;
        tick();
        n_checks++;
        if ({flush_ex, epc} !== {1'b1, 32'h300}) begin
            n_fails++; $display("FAIL post_reset_entry got fx=%b epc=%h want 1 300", flush_ex, epc);
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) == 0, $urandom, $urandom);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fails++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (m_mode == M_HALT && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_ovf();
        test_both();
        test_eret();
        test_double();
        test_hold();
        test_saturation();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
